vw_g2u_clk_mon: RTL and testbench

Synthesizable clock monitor: the measuring counterpart to the bench clock generator and divider. It samples a monitored clock in the `i_clk` domain, measures period and high time in `i_clk` cycles, and checks the period against an expected window. It reports lock, period-range errors and stuck-clock errors. Benches use it to confirm that generated or divided clocks have the configured frequency and duty cycle.

---
 rtl/vw_g2u_clk_mon.sv | 235 +++++++++++++++++++++++
 tb/tb_vw_g2u_clk_mon.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vw_g2u_clk_mon.sv
// vw_g2u_clk_mon: measures period and high time of an asynchronous monitored
// clock in reference-clock cycles, checks the period against a tolerance
// window, and reports lock, out-of-window and stuck-clock conditions.
`timescale 1ns/1ps
module vw_g2u_clk_mon #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 8,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 64,
  parameter int SETTLE     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_mon_clk,
  input  logic             i_clr_err,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_meas_vld,
  output logic             o_locked,
  output logic             o_err_period,
  output logic             o_err_stuck
);

  localparam int GW = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    GOOD_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0]    GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0]    SETTLE_C  = GW'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Saturating add of a single-bit increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             inc);
    logic [CNT_W-1:0] res;
    if (val == CNT_MAX) begin
      res = val;
    end else begin
      res = val + {{(CNT_W-1){1'b0}}, inc};
    end
    return res;
  endfunction

  state_t           state_r, state_nxt_s;
  logic             meta_r, s_r, d_r, rise_r;
  logic [CNT_W-1:0] per_cnt_r, high_cnt_r, idle_cnt_r;
  logic [GW-1:0]    good_cnt_r;
  logic [CNT_W-1:0] period_r, high_r;
  logic             meas_vld_r, locked_r, err_period_r, err_stuck_r;

  logic             start_s, meas_s, timeout_s, run_s, in_win_s;

  // Synchronize the monitored clock and register its rising-edge pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_r <= 1'b0;
      s_r    <= 1'b0;
      d_r    <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      meta_r <= i_mon_clk;
      s_r    <= meta_r;
      d_r    <= s_r;
      rise_r <= s_r & ~d_r;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: arm on enable, run after the first edge, re-arm on timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_en) state_nxt_s = ST_ARM;
        else      state_nxt_s = ST_IDLE;
      end
      ST_ARM: begin
        if (!i_en)       state_nxt_s = ST_IDLE;
        else if (rise_r) state_nxt_s = ST_RUN;
        else             state_nxt_s = ST_ARM;
      end
      ST_RUN: begin
        if (!i_en)          state_nxt_s = ST_IDLE;
        else if (timeout_s) state_nxt_s = ST_ARM;
        else                state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control decode: start of first period, measurement, timeout, counting.
  always_comb begin
    start_s   = 1'b0;
    meas_s    = 1'b0;
    timeout_s = 1'b0;
    run_s     = 1'b0;
    in_win_s  = (per_cnt_r >= WIN_LO) && (per_cnt_r <= WIN_HI);
    case (state_r)
      ST_ARM: begin
        if (i_en) begin
          start_s   = rise_r;
          timeout_s = ~rise_r && (idle_cnt_r == TIMEOUT_C);
        end else begin
          start_s   = 1'b0;
        end
      end
      ST_RUN: begin
        if (i_en) begin
          meas_s    = rise_r;
          timeout_s = ~rise_r && (idle_cnt_r == TIMEOUT_C);
          run_s     = ~rise_r && (idle_cnt_r != TIMEOUT_C);
        end else begin
          meas_s    = 1'b0;
        end
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Period and high-time counters; reload to 1 on each edge, cleared otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      per_cnt_r  <= CNT_ZERO;
      high_cnt_r <= CNT_ZERO;
    end else if (start_s || meas_s) begin
      per_cnt_r  <= CNT_ONE;
      high_cnt_r <= CNT_ONE;
    end else if (run_s) begin
      per_cnt_r  <= sat_inc(per_cnt_r, 1'b1);
      high_cnt_r <= sat_inc(high_cnt_r, s_r);
    end else begin
      per_cnt_r  <= CNT_ZERO;
      high_cnt_r <= CNT_ZERO;
    end
  end

  // Cycles since the last edge or since entering ARM, for stuck detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idle_cnt_r <= CNT_ZERO;
    end else if (!i_en) begin
      idle_cnt_r <= CNT_ZERO;
    end else if (state_r == ST_IDLE || rise_r || timeout_s) begin
      idle_cnt_r <= CNT_ONE;
    end else begin
      idle_cnt_r <= idle_cnt_r + CNT_ONE;
    end
  end

  // Consecutive in-window period count, saturating at the settle depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      good_cnt_r <= GOOD_ZERO;
    end else if (!i_en || timeout_s) begin
      good_cnt_r <= GOOD_ZERO;
    end else if (meas_s) begin
      if (!in_win_s)                    good_cnt_r <= GOOD_ZERO;
      else if (good_cnt_r == SETTLE_C)  good_cnt_r <= good_cnt_r;
      else                              good_cnt_r <= good_cnt_r + GOOD_ONE;
    end else begin
      good_cnt_r <= good_cnt_r;
    end
  end

  // Measurement results and the one-cycle valid strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      period_r   <= CNT_ZERO;
      high_r     <= CNT_ZERO;
      meas_vld_r <= 1'b0;
    end else begin
      meas_vld_r <= meas_s;
      if (meas_s) begin
        period_r <= per_cnt_r;
        high_r   <= high_cnt_r;
      end else begin
        period_r <= period_r;
        high_r   <= high_r;
      end
    end
  end

  // Lock flag follows the settled good count one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      locked_r <= 1'b0;
    end else begin
      locked_r <= (good_cnt_r == SETTLE_C);
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_period_r <= 1'b0;
      err_stuck_r  <= 1'b0;
    end else begin
      if (meas_s && !in_win_s) err_period_r <= 1'b1;
      else if (i_clr_err)      err_period_r <= 1'b0;
      else                     err_period_r <= err_period_r;
      if (timeout_s)           err_stuck_r  <= 1'b1;
      else if (i_clr_err)      err_stuck_r  <= 1'b0;
      else                     err_stuck_r  <= err_stuck_r;
    end
  end

  assign o_period     = period_r;
  assign o_high       = high_r;
  assign o_meas_vld   = meas_vld_r;
  assign o_locked     = locked_r;
  assign o_err_period = err_period_r;
  assign o_err_stuck  = err_stuck_r;

endmodule

// File: tb/tb_vw_g2u_clk_mon.sv
// Directed bench for vw_g2u_clk_mon: 10 ns reference clock, monitored clock
// with programmable high/low time latched at the start of each period.
`timescale 1ns/1ps
module tb_vw_g2u_clk_mon;

  logic        clk = 1'b0;
  logic        rst, en, mon_clk, clr;
  logic [15:0] period, high;
  logic        meas_vld, locked, err_period, err_stuck;

  int n_assert = 0;
  int n_fail   = 0;
  int mon_hi   = 40;
  int mon_lo   = 40;
  bit mon_run  = 1'b0;
  int n_cyc;
  bit saw_vld;

  vw_g2u_clk_mon #(
    .CNT_W(16), .EXP_PERIOD(8), .TOL(1), .TIMEOUT(64), .SETTLE(2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_mon_clk   (mon_clk),
    .i_clr_err   (clr),
    .o_period    (period),
    .o_high      (high),
    .o_meas_vld  (meas_vld),
    .o_locked    (locked),
    .o_err_period(err_period),
    .o_err_stuck (err_stuck)
  );

  always #5 clk = ~clk;

  // Monitored clock: edges land 3 ns after a reference rising edge.
  initial begin
    int cur_hi, cur_lo;
    mon_clk = 1'b0;
    forever begin
      if (mon_run) begin
        cur_hi  = mon_hi;
        cur_lo  = mon_lo;
        mon_clk = 1'b1;
        #(cur_hi);
        mon_clk = 1'b0;
        #(cur_lo);
      end else begin
        @(posedge clk);
        #3;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(input int max_cyc, output int n);
    n = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (meas_vld === 1'b1) begin
        n = i;
        break;
      end
    end
    check("vld_timeout", 32'(n > 0), 32'd1);
  endtask

  task automatic meas(input string tag, input int p, input int h, input int lk, output int n);
    wait_vld(40, n);
    check({tag, "_period"}, 32'(period), 32'(p));
    check({tag, "_high"},   32'(high),   32'(h));
    check({tag, "_locked"}, 32'(locked), 32'(lk));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period",     32'(period),     32'd0);
    check("rst_high",       32'(high),       32'd0);
    check("rst_vld",        32'(meas_vld),   32'd0);
    check("rst_locked",     32'(locked),     32'd0);
    check("rst_err_period", 32'(err_period), 32'd0);
    check("rst_err_stuck",  32'(err_stuck),  32'd0);

    // Nominal 80 ns / 50 % clock: lock after the second measurement.
    rst = 1'b0; en = 1'b1; mon_run = 1'b1;
    meas("nom1", 8, 4, 0, n_cyc);
    meas("nom2", 8, 4, 0, n_cyc);
    @(negedge clk);
    check("vld_single",     32'(meas_vld),   32'd0);
    check("nom_locked",     32'(locked),     32'd1);
    check("nom_err_period", 32'(err_period), 32'd0);
    check("nom_err_stuck",  32'(err_stuck),  32'd0);

    // 100 ns period while locked: error, lock drops; back to 80 ns relocks.
    mon_hi = 50; mon_lo = 50;
    meas("old", 8, 4, 1, n_cyc);
    meas("slow", 10, 5, 1, n_cyc);
    check("slow_err", 32'(err_period), 32'd1);
    @(negedge clk);
    check("slow_unlock", 32'(locked), 32'd0);
    mon_hi = 40; mon_lo = 40;
    meas("slow2",   10, 5, 0, n_cyc);
    meas("relock1", 8, 4, 0, n_cyc);
    meas("relock2", 8, 4, 0, n_cyc);
    @(negedge clk);
    check("relock",   32'(locked),     32'd1);
    check("err_hold", 32'(err_period), 32'd1);

    // Clear keeps lock; clear held during a bad report loses to the set.
    clr = 1'b1;
    @(negedge clk);
    check("clr_err",    32'(err_period), 32'd0);
    check("clr_locked", 32'(locked),     32'd1);
    mon_hi = 50; mon_lo = 50;
    meas("clr_old", 8, 4, 1, n_cyc);
    meas("clr_bad", 10, 5, 1, n_cyc);
    check("collide", 32'(err_period), 32'd1);
    clr = 1'b0;
    @(negedge clk);
    check("collide_hold",   32'(err_period), 32'd1);
    check("collide_unlock", 32'(locked),     32'd0);

    // 90 ns period, 30 ns high: upper window edge, still locks.
    mon_hi = 30; mon_lo = 60;
    meas("duty_prev", 10, 5, 0, n_cyc);
    meas("duty1", 9, 3, 0, n_cyc);
    meas("duty2", 9, 3, 0, n_cyc);
    @(negedge clk);
    check("duty_lock", 32'(locked), 32'd1);

    // Stuck low: error exactly 64 cycles after the last edge was taken.
    mon_run = 1'b0;
    repeat (62) @(negedge clk);
    check("stuck_early", 32'(err_stuck), 32'd0);
    @(negedge clk);
    check("stuck_set",    32'(err_stuck), 32'd1);
    check("stuck_period", 32'(period),    32'd9);
    @(negedge clk);
    check("stuck_unlock", 32'(locked), 32'd0);

    // Restore: re-arm, first report one period after the first edge.
    clr = 1'b1; mon_hi = 40; mon_lo = 40; mon_run = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("stuck_clr", 32'(err_stuck), 32'd0);
    meas("rearm1", 8, 4, 0, n_cyc);
    check("rearm_latency", 32'(n_cyc), 32'd12);
    meas("rearm2", 8, 4, 0, n_cyc);
    @(negedge clk);
    check("rearm_lock", 32'(locked), 32'd1);

    // One-cycle reset mid-period while locked.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_period", 32'(period),     32'd0);
    check("mrst_high",   32'(high),       32'd0);
    check("mrst_vld",    32'(meas_vld),   32'd0);
    check("mrst_locked", 32'(locked),     32'd0);
    check("mrst_errp",   32'(err_period), 32'd0);
    check("mrst_errs",   32'(err_stuck),  32'd0);
    meas("post_rst", 8, 4, 0, n_cyc);

    // Disable: no reports, results hold, lock stays low; re-enable measures.
    en = 1'b0;
    saw_vld = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (meas_vld === 1'b1) saw_vld = 1'b1;
    end
    check("dis_no_vld", 32'(saw_vld), 32'd0);
    check("dis_period", 32'(period),  32'd8);
    check("dis_locked", 32'(locked),  32'd0);
    en = 1'b1;
    meas("reen", 8, 4, 0, n_cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
